// File: rtl/music_box_state_timed_recording_if.sv
// ---------------------------------------------------------------------------
// music_box_state_timed_recording_if
//   Sample-in / memory-write bundle of the timed recording state.
//
//   Handshake: there is no back-pressure on either side. sample_valid is a
//   one-cycle strobe qualifying sample_data; the consumer must take it in that
//   cycle. write_enable is a one-cycle strobe qualifying write_address and
//   write_data, issued exactly one cycle after the accepted sample_valid.
//
//   Modports:
//     master : sample source / memory sink (drives sample_*, sees write_*)
//     slave  : recorder (sees sample_*, drives write_*)
// ---------------------------------------------------------------------------
interface music_box_state_timed_recording_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport master (
    output sample_valid, sample_data,
    input  write_enable, write_address, write_data
  );

  modport slave (
    input  sample_valid, sample_data,
    output write_enable, write_address, write_data
  );
endinterface

// File: rtl/music_box_state_timed_recording.sv
// ---------------------------------------------------------------------------
// music_box_state_timed_recording
//   Recording state of the MusicBox UI. While currentState == STATE_ID it
//   times the take in 1 ms ticks and streams incoming samples into recording
//   memory as sequential writes. The take ends on timeout, user stop or full
//   buffer, after which stateComplete is raised until the controller moves on.
//
//   Ports:
//     clock_50Mhz, reset_n  : clock, asynchronous active-low reset
//     currentState[4:0]     : controller state, activates the block
//     tick_1khz             : 1 ms enable pulse
//     stop_request          : user stop (level)
//     rec_if (slave)        : sample strobe in, memory write strobe out
//     recording_active      : high while recording
//     elapsed_ms            : ms elapsed in current / last take
//     recorded_length       : samples captured (0..DEPTH)
//     stateComplete         : take finished normally
//     debugString[31:0]     : {state[1:0], length[13:0], elapsed[15:0]}
//
//   Build option: MUSICBOX_REC_MIN_LEN_EN -- when defined, a stop request is
//   only honoured once elapsed_ms has reached MIN_MS.
// ---------------------------------------------------------------------------
module music_box_state_timed_recording #(
  parameter int STATE_ID    = 4,
  parameter int DURATION_MS = 5000,
  parameter int CNT_W       = 16,
  parameter int DEPTH       = 32768,
  parameter int DATA_W      = 8,
  parameter int MIN_MS      = 500,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int LEN_W      = ADDR_W + 1
) (
  input  logic                 clock_50Mhz,
  input  logic                 reset_n,
  input  logic [4:0]           currentState,
  input  logic                 tick_1khz,
  input  logic                 stop_request,
  music_box_state_timed_recording_if.slave rec_if,
  output logic                 recording_active,
  output logic [CNT_W-1:0]     elapsed_ms,
  output logic [LEN_W-1:0]     recorded_length,
  output logic                 stateComplete,
  output logic [31:0]          debugString
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DUR_LIMIT = CNT_W'(DURATION_MS);
  localparam logic [LEN_W-1:0] LAST_ADDR = LEN_W'(DEPTH - 1);

  state_t              state_q,   state_d;
  logic [CNT_W-1:0]    elapsed_q, elapsed_d;
  // One bit wider than the address so it can reach DEPTH without wrapping.
  logic [LEN_W-1:0]    addr_q,    addr_d;
  logic [LEN_W-1:0]    len_q,     len_d;
  logic                we_q,      we_d;
  logic [ADDR_W-1:0]   waddr_q,   waddr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;

  logic in_state;
  logic stop_ok;
  logic finish;

  assign in_state = (currentState == 5'(STATE_ID));

`ifdef MUSICBOX_REC_MIN_LEN_EN
  // Compared against the count before this cycle's tick, so a request held
  // across the MIN_MS tick takes effect on the following cycle.
  assign stop_ok = stop_request && (elapsed_q >= CNT_W'(MIN_MS));
`else
  // MIN_MS is legal only as a non-negative value, so this term is always
  // true; the minimum-length gate exists only in the optional build.
  assign stop_ok = stop_request && (MIN_MS >= 0);
`endif

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    addr_d    = addr_q;
    len_d     = len_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_state) begin
          state_d   = REC;
          elapsed_d = '0;
          addr_d    = '0;
          len_d     = '0;
        end
      end

      REC: begin
        if (!in_state) begin
          // Abort: the take is discarded, elapsed time is kept for display.
          state_d = IDLE;
          len_d   = '0;
        end else begin
          if (rec_if.sample_valid) begin
            we_d    = 1'b1;
            waddr_d = addr_q[ADDR_W-1:0];
            wdata_d = rec_if.sample_data;
            addr_d  = addr_q + LEN_W'(1);
            len_d   = len_q + LEN_W'(1);
            if (addr_q == LAST_ADDR) finish = 1'b1;
          end
          if (tick_1khz) begin
            elapsed_d = elapsed_q + CNT_W'(1);
            if (elapsed_q + CNT_W'(1) == DUR_LIMIT) finish = 1'b1;
          end
          if (stop_ok) finish = 1'b1;
          if (finish) state_d = DONE;
        end
      end

      DONE: begin
        if (!in_state) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rec_if.write_enable  = we_q;
  assign rec_if.write_address = waddr_q;
  assign rec_if.write_data    = wdata_q;

  assign recording_active = (state_q == REC);
  assign stateComplete    = (state_q == DONE);
  assign elapsed_ms       = elapsed_q;
  assign recorded_length  = len_q;
  assign debugString      = {state_q, 14'(len_q), 16'(elapsed_q)};

endmodule

// File: tb/tb_music_box_state_timed_recording.sv
module tb_music_box_state_timed_recording;

  localparam int SID = 4;
  localparam int DUR = 20;
  localparam int DEP = 8;
  localparam int MIN = 10;
  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int LW  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  logic [4:0]    cs;
  logic          tick;
  logic          stop;
  logic          rec_active;
  logic [15:0]   elapsed;
  logic [LW-1:0] rec_len;
  logic          complete;
  logic [31:0]   dbg;

  music_box_state_timed_recording_if #(.DATA_W(DW), .ADDR_W(AW)) rec_if ();

  music_box_state_timed_recording #(
    .STATE_ID(SID), .DURATION_MS(DUR), .CNT_W(16),
    .DEPTH(DEP), .DATA_W(DW), .MIN_MS(MIN)
  ) dut (
    .clock_50Mhz      (clk),
    .reset_n          (rst_n),
    .currentState     (cs),
    .tick_1khz        (tick),
    .stop_request     (stop),
    .rec_if           (rec_if.slave),
    .recording_active (rec_active),
    .elapsed_ms       (elapsed),
    .recorded_length  (rec_len),
    .stateComplete    (complete),
    .debugString      (dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 recording, 2 done
  int m_mode, m_el, m_len, m_next;
  bit m_we;
  logic [AW+DW-1:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_el = 0; m_len = 0; m_next = 0; m_we = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    bit ends;
    bit stop_ok;
    ends = 0;
    m_we = 0;
`ifdef MUSICBOX_REC_MIN_LEN_EN
    stop_ok = stop && (m_el >= MIN);
`else
    stop_ok = stop;
`endif
    if (m_mode == 0) begin
      if (cs == SID) begin
        m_mode = 1; m_el = 0; m_len = 0; m_next = 0;
      end
    end else if (m_mode == 1) begin
      if (cs != SID) begin
        m_mode = 0; m_len = 0;
      end else begin
        if (rec_if.sample_valid) begin
          exp_q.push_back({AW'(m_next), rec_if.sample_data});
          m_we = 1;
          m_next++;
          m_len++;
          if (m_next == DEP) ends = 1;
        end
        if (tick) begin
          m_el++;
          if (m_el == DUR) ends = 1;
        end
        if (stop_ok) ends = 1;
        if (ends) m_mode = 2;
      end
    end else begin
      if (cs != SID) m_mode = 0;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_dbg;
    logic [AW+DW-1:0] e;
    exp_dbg = {2'(m_mode), 14'(m_len), 16'(m_el)};
    check_val("active",   32'(rec_active), 32'(m_mode == 1));
    check_val("complete", 32'(complete),   32'(m_mode == 2));
    check_val("elapsed",  32'(elapsed),    32'(m_el));
    check_val("length",   32'(rec_len),    32'(m_len));
    check_val("debug",    dbg,             exp_dbg);
    check_val("wr_en",    32'(rec_if.write_enable), 32'(m_we));
    if (rec_if.write_enable) wr_cnt++;
    if (m_we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("wr_addr", 32'(rec_if.write_address), 32'(e[AW+DW-1:DW]));
      check_val("wr_data", 32'(rec_if.write_data),    32'(e[DW-1:0]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [4:0] c, input logic t, input logic s,
                       input logic v, input logic [7:0] d);
    cs = c; tick = t; stop = s;
    rec_if.sample_valid = v;
    rec_if.sample_data  = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_cycle();
    cycle(5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic enter_rec();
    idle_cycle();
    cycle(5'(SID), 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] rc;
    bit         seen;
    rst_n = 1'b0;
    cs = 5'd0; tick = 1'b0; stop = 1'b0;
    rec_if.sample_valid = 1'b0;
    rec_if.sample_data  = 8'h00;
    model_reset();
    #25;
    check_val("rst_active",   32'(rec_active), 32'd0);
    check_val("rst_complete", 32'(complete),   32'd0);
    check_val("rst_debug",    dbg,             32'd0);
    check_val("rst_wr_en",    32'(rec_if.write_enable), 32'd0);
    #10 rst_n = 1'b1;

    // Timeout: sample every 3 ticks starting with the first tick.
    enter_rec();
    wr_cnt = 0;
    for (int k = 0; k < DUR; k++) begin
      cycle(5'(SID), 1'b1, 1'b0, 1'((k % 3) == 0), 8'($urandom_range(0, 255)));
      cycle(5'(SID), 1'b0, 1'b0, 1'b0, 8'h00);
    end
    cycle(5'(SID), 1'b0, 1'b0, 1'b0, 8'h00);
    check_val("timeout_elapsed",  32'(elapsed),  32'd20);
    check_val("timeout_length",   32'(rec_len),  32'd7);
    check_val("timeout_complete", 32'(complete), 32'd1);
    check_val("timeout_writes",   32'(wr_cnt),   32'd7);

    // Full buffer: sample every cycle, extra strobes after DONE.
    enter_rec();
    wr_cnt = 0;
    for (int k = 0; k < DEP + 3; k++)
      cycle(5'(SID), 1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
    check_val("full_length",   32'(rec_len),  32'(DEP));
    check_val("full_writes",   32'(wr_cnt),   32'(DEP));
    check_val("full_complete", 32'(complete), 32'd1);

    // Stop after 5 ms, request held while ticks continue.
    enter_rec();
    for (int k = 0; k < 5; k++) cycle(5'(SID), 1'b1, 1'b0, 1'b0, 8'h00);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle(5'(SID), 1'((i % 3) == 2), 1'b1, 1'b0, 8'h00);
      seen = complete;
    end
    check_val("stop_complete", 32'(complete), 32'd1);
`ifdef MUSICBOX_REC_MIN_LEN_EN
    check_val("stop_elapsed", 32'(elapsed), 32'd10);
`else
    check_val("stop_elapsed", 32'(elapsed), 32'd5);
`endif

    // Abort at 3 ms, then re-entry restarts at address 0.
    enter_rec();
    cycle(5'(SID), 1'b1, 1'b0, 1'b1, 8'h11);
    cycle(5'(SID), 1'b1, 1'b0, 1'b1, 8'h22);
    cycle(5'(SID), 1'b1, 1'b0, 1'b0, 8'h00);
    idle_cycle();
    check_val("abort_complete", 32'(complete), 32'd0);
    check_val("abort_length",   32'(rec_len),  32'd0);
    check_val("abort_elapsed",  32'(elapsed),  32'd3);
    cycle(5'(SID), 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(5'(SID), 1'b0, 1'b0, 1'b1, 8'h5A);
    check_val("reentry_addr", 32'(rec_if.write_address), 32'd0);

    // Sample coincident with the terminating tick; later sample ignored.
    enter_rec();
    for (int k = 0; k < DUR - 1; k++) cycle(5'(SID), 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(5'(SID), 1'b1, 1'b0, 1'b1, 8'hA5);
    check_val("sim_wr_en",    32'(rec_if.write_enable), 32'd1);
    check_val("sim_wr_data",  32'(rec_if.write_data),   32'hA5);
    check_val("sim_length",   32'(rec_len),             32'd1);
    check_val("sim_complete", 32'(complete),            32'd1);
    cycle(5'(SID), 1'b0, 1'b0, 1'b1, 8'h33);
    check_val("sim_done_no_write", 32'(rec_if.write_enable), 32'd0);

    // Asynchronous reset in the middle of a take.
    enter_rec();
    cycle(5'(SID), 1'b1, 1'b0, 1'b1, 8'h77);
    #4 rst_n = 1'b0;
    #1;
    check_val("arst_active",  32'(rec_active), 32'd0);
    check_val("arst_elapsed", 32'(elapsed),    32'd0);
    check_val("arst_length",  32'(rec_len),    32'd0);
    check_val("arst_wr_en",   32'(rec_if.write_enable), 32'd0);
    check_val("arst_debug",   dbg,             32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 24) == 0) rc = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd3;
      else                            rc = 5'(SID);
      cycle(rc, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/music_box_state_timed_recording.md
Name: music_box_state_timed_recording

Overview:
- Parametrised successor to the fixed 5 s recording-state timer in the MusicBox UI state layer.
- Active only while `currentState` equals `STATE_ID`. Times the recording in 1 ms ticks and captures incoming audio samples into recording memory as sequential write strobes and addresses.
- Terminates on timeout, on the user stop request, or on a full buffer. Raises `stateComplete` so `MusicBoxStateController` returns to DoNothing.
- Runs entirely on `clock_50Mhz`; the 1 kHz rate arrives as a single-cycle enable, not as a second clock.

Parameters:
- `STATE_ID`, 4: `currentState` value that activates the block.
- `DURATION_MS`, 5000: maximum recording length in ms ticks; legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, 16: width of the elapsed-ms counter.
- `DEPTH`, 32768: recording memory depth in samples; power of two, at least 2.
- `DATA_W`, 8: sample width.
- `MIN_MS`, 500: minimum length before a stop request is honoured; used only with the optional feature.

Ports:
- `clock_50Mhz`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `currentState`, in, 5: state from `MusicBoxStateController`.
- `tick_1khz`, in, 1: one-cycle pulse every 1 ms, synchronous to `clock_50Mhz`.
- `stop_request`, in, 1: user stop; level, sampled every cycle.
- `sample_valid`, in, 1: one-cycle strobe marking a new sample.
- `sample_data`, in, `DATA_W`: sample value, valid while `sample_valid`=1.
- `write_enable`, out, 1: one-cycle memory write strobe.
- `write_address`, out, log2(`DEPTH`): memory address for the current write.
- `write_data`, out, `DATA_W`: memory data for the current write.
- `recording_active`, out, 1: high while in REC.
- `elapsed_ms`, out, `CNT_W`: ms elapsed in the current or last recording.
- `recorded_length`, out, log2(`DEPTH`)+1: number of samples captured.
- `stateComplete`, out, 1: recording finished normally.
- `debugString`, out, 32: debug visibility.

Behaviour:
- Reset (asynchronous, `reset_n`=0):
  - state goes to IDLE.
  - All outputs go to 0, and the internal address counter is cleared.
- IDLE:
  - Enter REC when `currentState`==`STATE_ID`. That cycle clears `elapsed_ms`, the address counter and `recorded_length`.
  - `recording_active` rises one cycle after `currentState` matches.
- REC, timing:
  - Each `tick_1khz` increments `elapsed_ms`.
  - The tick that makes `elapsed_ms`==`DURATION_MS` moves the block to DONE.
- REC, capture:
  - Each `sample_valid` produces, on the next cycle: `write_enable`=1, `write_address`=address counter, `write_data`=`sample_data`.
  - The address counter and `recorded_length` increment in that same cycle.
  - Exactly one write per strobe; latency is 1 cycle.
- Full buffer: the write to address `DEPTH`-1 moves the block to DONE. The address counter never wraps, so `recorded_length` ends at `DEPTH`.
- `stop_request`=1 in REC moves the block to DONE on the next cycle.
- Simultaneous events:
  - If `sample_valid` arrives in the same cycle as a terminating event (tick reaching the limit, stop, or full), that sample is still written.
  - Samples arriving in DONE or IDLE are ignored.
  - `tick_1khz` and `sample_valid` arriving together are both processed.
- DONE:
  - `recording_active`=0 and `stateComplete`=1.
  - `elapsed_ms` and `recorded_length` are held.
  - Leave for IDLE when `currentState`!=`STATE_ID`; `stateComplete` drops in that same cycle.
- Abort: if `currentState` leaves `STATE_ID` during REC:
  - Go to IDLE with `stateComplete` still 0.
  - Clear `recorded_length` to 0, since the recording is invalid.
  - Hold `elapsed_ms`.
  - Any in-flight write strobe from the previous cycle still completes.
- Re-entry: `currentState` returning to `STATE_ID` from IDLE always starts a fresh recording.
- `debugString` layout:
  - [31:30] = state code (IDLE=0, REC=1, DONE=2).
  - [29:16] = `recorded_length`, zero-extended or truncated to 14 bits.
  - [15:0] = `elapsed_ms`, zero-extended or truncated to 16 bits.

Optional Feature:
- Macro: `MUSICBOX_REC_MIN_LEN_EN`.
- Defined: `stop_request` is ignored in REC while `elapsed_ms` < `MIN_MS`. A request still held when `elapsed_ms` reaches `MIN_MS` is honoured on the next cycle. Timeout and full buffer are unaffected.
- Undefined: `stop_request` is honoured immediately, and `MIN_MS` is unused.

Test Plan:
- Timeout: `DURATION_MS`=20, `currentState`=4, one sample every 3 ticks, no stop → `stateComplete`=1 after the 20th tick, `elapsed_ms`=20, `recorded_length`=7 (first sample on tick 0), addresses 0..6 written in order.
- Full buffer: `DEPTH`=8, `sample_valid` every cycle → 8 writes to addresses 0..7, DONE one cycle after the 8th strobe, `recorded_length`=8, no 9th write.
- Stop: `stop_request` at `elapsed_ms`=5, macro undefined → DONE next cycle, `elapsed_ms`=5. Same test with macro defined and `MIN_MS`=10, stop held → DONE at `elapsed_ms`=10.
- Abort: `currentState` 4→0 at `elapsed_ms`=3 → IDLE, `stateComplete` never 1, `recorded_length`=0. Re-entry restarts writes at address 0.
- Simultaneous events: `sample_valid` coincides with the terminating tick → sample written with `write_enable`=1 one cycle later, `recorded_length` includes it, and a later `sample_valid` in DONE produces no write.
- Reset mid-REC: `reset_n`=0 asynchronously → all outputs 0 immediately, without waiting for a clock edge.
